// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: PC source encodings, pc_gen FSM states, default datapath width.
package msrv32_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] PC_SRC_BOOT = 2'b00;
   localparam logic [1:0] PC_SRC_EPC  = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP = 2'b10;
   localparam logic [1:0] PC_SRC_NEXT = 2'b11;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } pc_state_e;

endpackage

// File: rtl/msrv32_pc_redirect_buf.sv
// Single-entry buffer for a redirect that arrives while the instruction bus is stalled.
// First redirect is captured; while held, only trap/boot sources may overwrite it.
module msrv32_pc_redirect_buf
   import msrv32_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            capture,
   input  logic            offer,
   input  logic            clear,
   input  logic [1:0]      src_in,
   input  logic [XLEN-1:0] target_in,
   output logic            valid,
   output logic [XLEN-1:0] target
);

   logic high_prio;

   assign high_prio = (src_in == PC_SRC_TRAP) || (src_in == PC_SRC_BOOT);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid  <= 1'b0;
         target <= '0;
      end else if (clear) begin
         valid  <= 1'b0;
      end else if (!valid && capture) begin
         valid  <= 1'b1;
         target <= target_in;
      end else if (valid && offer && high_prio) begin
         target <= target_in;
      end
   end

endmodule

// File: rtl/msrv32_pc_gen.sv
// Registered PC generator: boot delay, AHB wait-state stall, buffered redirect, misalign detect.
// Define MSRV32_PC_RVC_EN for compressed-instruction support (2-byte alignment, no misalign trap).
//
// state | meaning
// BOOT  | post-reset delay, PC held at BOOT_ADDR, no fetch request
// RUN   | normal fetch, PC advances when bus is ready
// HOLD  | bus stalled with a redirect buffered, waiting for ready
module msrv32_pc_gen
   import msrv32_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEF,
   parameter logic [XLEN-1:0] BOOT_ADDR = '0,
   parameter int              BOOT_WAIT = 4
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [1:0]      pc_src_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic [XLEN-1:0] trap_address_in,
   input  logic            branch_taken_in,
   input  logic [XLEN-2:0] iaddr_in,
   input  logic            ahb_ready_in,
`ifdef MSRV32_PC_RVC_EN
   input  logic            is_compressed_in,
`endif
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] iaddr_out,
   output logic [XLEN-1:0] pc_plus_4_out,
   output logic [XLEN-1:0] pc_mux_out,
   output logic            fetch_valid_out,
   output logic            redirect_pending_out,
   output logic            misaligned_instr_logic_out
);

`ifdef MSRV32_PC_RVC_EN
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);
`else
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
`endif

   pc_state_e       state_q, state_d;
   logic [31:0]     boot_cnt;
   logic            boot_done;
   logic [XLEN-1:0] pc_q, pc_d, iaddr_q;
   logic [XLEN-1:0] next_seq, branch_tgt;
   logic            redirect, misaligned, mis_q, mis_d;
   logic            capture, offer, commit;
   logic            pend_valid;
   logic [XLEN-1:0] pend_tgt;

`ifdef MSRV32_PC_RVC_EN
   assign next_seq   = pc_q + (is_compressed_in ? XLEN'(2) : XLEN'(4));
   assign misaligned = 1'b0;
`else
   assign next_seq   = pc_q + XLEN'(4);
   assign misaligned = (pc_src_in == PC_SRC_NEXT) && branch_taken_in && branch_tgt[1];
`endif

   assign branch_tgt = {iaddr_in, 1'b0};
   assign redirect   = (pc_src_in != PC_SRC_NEXT) || branch_taken_in;
   assign boot_done  = (BOOT_WAIT == 0) || (boot_cnt == 32'(BOOT_WAIT - 1));

   always_comb begin
      case (pc_src_in)
         PC_SRC_BOOT: pc_mux_out = BOOT_ADDR;
         PC_SRC_EPC:  pc_mux_out = epc_in;
         PC_SRC_TRAP: pc_mux_out = trap_address_in;
         default:     pc_mux_out = branch_taken_in ? branch_tgt : next_seq;
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mis_d   = 1'b0;
      capture = 1'b0;
      offer   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            if (boot_done) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ahb_ready_in) begin
               if (misaligned) mis_d = 1'b1;
               else            pc_d  = pc_mux_out;
            end else if (redirect) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Buffered target wins over whatever the mux presents this cycle
            if (ahb_ready_in) begin
               pc_d    = pend_tgt;
               commit  = 1'b1;
               state_d = ST_RUN;
            end else begin
               offer = 1'b1;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= ST_BOOT;
         boot_cnt <= '0;
         pc_q     <= BOOT_ADDR;
         iaddr_q  <= BOOT_ADDR & ALIGN_MASK;
         mis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         iaddr_q  <= pc_d & ALIGN_MASK;
         mis_q    <= mis_d;
         if (state_q == ST_BOOT) boot_cnt <= boot_cnt + 32'd1;
      end
   end

   msrv32_pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .capture   (capture),
      .offer     (offer),
      .clear     (commit),
      .src_in    (pc_src_in),
      .target_in (pc_mux_out),
      .valid     (pend_valid),
      .target    (pend_tgt)
   );

   assign pc_out                     = pc_q;
   assign iaddr_out                  = iaddr_q;
   assign pc_plus_4_out              = pc_q + XLEN'(4);
   assign fetch_valid_out            = (state_q != ST_BOOT);
   assign redirect_pending_out       = pend_valid;
   assign misaligned_instr_logic_out = mis_q;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Directed bench for msrv32_pc_gen (default build, BOOT_WAIT=4, BOOT_ADDR=0).
module tb_msrv32_pc_gen;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [1:0]  pc_src_in;
   logic [31:0] epc_in, trap_address_in;
   logic        branch_taken_in;
   logic [30:0] iaddr_in;
   logic        ahb_ready_in;
   logic [31:0] pc_out, iaddr_out, pc_plus_4_out, pc_mux_out;
   logic        fetch_valid_out, redirect_pending_out, misaligned_instr_logic_out;

   int tests  = 0;
   int failed = 0;

   msrv32_pc_gen #(.XLEN(32), .BOOT_ADDR(32'h0), .BOOT_WAIT(4)) dut (
      .clk_in                     (clk_in),
      .rst_in                     (rst_in),
      .pc_src_in                  (pc_src_in),
      .epc_in                     (epc_in),
      .trap_address_in            (trap_address_in),
      .branch_taken_in            (branch_taken_in),
      .iaddr_in                   (iaddr_in),
      .ahb_ready_in               (ahb_ready_in),
      .pc_out                     (pc_out),
      .iaddr_out                  (iaddr_out),
      .pc_plus_4_out              (pc_plus_4_out),
      .pc_mux_out                 (pc_mux_out),
      .fetch_valid_out            (fetch_valid_out),
      .redirect_pending_out       (redirect_pending_out),
      .misaligned_instr_logic_out (misaligned_instr_logic_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_in = 1'b1; pc_src_in = 2'b11; epc_in = '0; trap_address_in = '0;
      branch_taken_in = 1'b0; iaddr_in = '0; ahb_ready_in = 1'b1;
      step();
      check("rst_pc", pc_out, 32'h0);
      check("rst_iaddr", iaddr_out, 32'h0);
      check("rst_fv", 32'(fetch_valid_out), 32'h0);
      check("rst_pend", 32'(redirect_pending_out), 32'h0);
      check("rst_mis", 32'(misaligned_instr_logic_out), 32'h0);
      rst_in = 1'b0;

      for (int i = 1; i <= 3; i++) begin
         step();
         check("boot_fv", 32'(fetch_valid_out), 32'h0);
         check("boot_iaddr", iaddr_out, 32'h0);
      end
      step();
      check("boot_exit_fv", 32'(fetch_valid_out), 32'h1);
      check("boot_exit_pc", pc_out, 32'h0);
      check("boot_exit_p4", pc_plus_4_out, 32'h4);

      step(); check("seq_pc1", pc_out, 32'h4); check("seq_p4_1", pc_plus_4_out, 32'h8);
      step(); check("seq_pc2", pc_out, 32'h8);
      step(); check("seq_pc3", pc_out, 32'hC); check("seq_iaddr3", iaddr_out, 32'hC);

      // Branch to 0x10 during a 3-cycle stall
      branch_taken_in = 1'b1; iaddr_in = 31'h8; ahb_ready_in = 1'b0;
      #1 check("br_mux", pc_mux_out, 32'h10);
      step();
      check("stall_pc1", pc_out, 32'hC); check("stall_pend1", 32'(redirect_pending_out), 32'h1);
      branch_taken_in = 1'b0;
      step(); check("stall_pc2", pc_out, 32'hC);
      step(); check("stall_pc3", pc_out, 32'hC); check("stall_pend3", 32'(redirect_pending_out), 32'h1);
      ahb_ready_in = 1'b1;
      step();
      check("br_commit_pc", pc_out, 32'h10);
      check("br_commit_iaddr", iaddr_out, 32'h10);
      check("br_commit_pend", 32'(redirect_pending_out), 32'h0);

      // Pending branch overwritten by trap, later mret ignored
      ahb_ready_in = 1'b0; branch_taken_in = 1'b1; iaddr_in = 31'h8;
      step(); check("hold2_pc", pc_out, 32'h10);
      branch_taken_in = 1'b0; pc_src_in = 2'b10; trap_address_in = 32'h30;
      step();
      pc_src_in = 2'b01; epc_in = 32'h50;
      step(); check("hold2_pend", 32'(redirect_pending_out), 32'h1);
      pc_src_in = 2'b11; ahb_ready_in = 1'b1;
      step();
      check("trap_win_pc", pc_out, 32'h30);
      check("trap_win_pend", 32'(redirect_pending_out), 32'h0);

      // Misaligned branch target 0x12
      branch_taken_in = 1'b1; iaddr_in = 31'h9;
      step();
      check("mis_pc", pc_out, 32'h30);
      check("mis_pulse", 32'(misaligned_instr_logic_out), 32'h1);
      branch_taken_in = 1'b0;
      step();
      check("mis_clear", 32'(misaligned_instr_logic_out), 32'h0);
      check("mis_next_pc", pc_out, 32'h34);

      // Wraparound at top of address space
      pc_src_in = 2'b10; trap_address_in = 32'hFFFF_FFFC;
      step();
      check("wrap_pc", pc_out, 32'hFFFF_FFFC);
      check("wrap_p4", pc_plus_4_out, 32'h0);
      pc_src_in = 2'b11;
      step();
      check("wrap_step_pc", pc_out, 32'h0);
      check("wrap_step_iaddr", iaddr_out, 32'h0);

      pc_src_in = 2'b01; epc_in = 32'h80;
      step(); check("epc_pc", pc_out, 32'h80);

      // Reset while holding a redirect to 0x40
      pc_src_in = 2'b11; ahb_ready_in = 1'b0; branch_taken_in = 1'b1; iaddr_in = 31'h20;
      step(); check("rsthold_pend", 32'(redirect_pending_out), 32'h1);
      rst_in = 1'b1;
      step();
      check("rsthold_pc", pc_out, 32'h0);
      check("rsthold_pendclr", 32'(redirect_pending_out), 32'h0);
      check("rsthold_fv", 32'(fetch_valid_out), 32'h0);
      rst_in = 1'b0; ahb_ready_in = 1'b1; branch_taken_in = 1'b0;
      step();
      check("reboot_pc", pc_out, 32'h0);
      check("reboot_fv", 32'(fetch_valid_out), 32'h0);
      step(); step(); step();
      check("reboot_run_fv", 32'(fetch_valid_out), 32'h1);
      step(); check("reboot_seq_pc", pc_out, 32'h4);

      // Boot source in RUN reloads BOOT_ADDR without re-entering BOOT
      pc_src_in = 2'b00;
      step();
      check("src00_pc", pc_out, 32'h0);
      check("src00_fv", 32'(fetch_valid_out), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
